alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set operand/result width (legal 8..64).
REQ-002 Parameter SHW, default 5, SHALL equal clog2(WIDTH), the width of shift amount fields.
REQ-003 Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-005 Start  input  1  SHALL request an operation; operands and Op are sampled in the same cycle.
REQ-006 Op  input  3  SHALL select the operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 MUL, 011 SLL, 101 SRL.
REQ-007 A, B  input  WIDTH each  SHALL be the operands.
REQ-008 SHAMT  input  SHW  SHALL be the base shift amount.
REQ-009 Busy  output  1  SHALL be high while a MUL is in progress.
REQ-010 Done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-011 Result  output  WIDTH  SHALL be the registered result (MUL: low half of the product).
REQ-012 MulHi  output  WIDTH  SHALL be the high half of the MUL product; 0 for other ops.
REQ-013 Zero, Overflow, CarryOut  output  1 each  SHALL be registered status flags.

Function
REQ-014 FSM states SHALL be IDLE, MUL, FIN; reset state IDLE.
REQ-015 Start SHALL be accepted only in IDLE; Start in MUL or FIN SHALL be ignored with no side effects.
REQ-016 Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, SRL) SHALL go IDLE->FIN on acceptance, load outputs at that edge, and pulse Done the following cycle (latency 1).
REQ-017 In FIN the FSM SHALL return to IDLE unconditionally after one cycle; Done SHALL be high only in FIN.
REQ-018 MUL SHALL be unsigned shift-add: operands latched on acceptance; one multiplier bit per cycle for WIDTH cycles in MUL, then FIN; Done SHALL occur WIDTH+1 cycles after the accepting edge.
REQ-019 Busy SHALL be high exactly in state MUL.
REQ-020 ADD/SUB SHALL use a WIDTH-bit two's-complement adder; SUB = A + ~B + 1.
REQ-021 CarryOut SHALL be the adder carry out of bit WIDTH-1 for ADD/SUB (SUB: 1 = no borrow); 0 otherwise.
REQ-022 Overflow SHALL be the signed overflow (carry into MSB XOR carry out) for ADD/SUB; 0 otherwise.
REQ-023 SLT SHALL return 1 in Result[0] if A < B signed (overflow-corrected sign), else 0; upper bits 0.
REQ-024 SLL/SRL shift distance SHALL be SHAMT + B[SHW-1:0] computed at SHW+1 bits; if the sum is >= WIDTH, Result SHALL be 0.
REQ-025 SRL SHALL be logical (zero-fill).
REQ-026 Zero SHALL be 1 iff Result is all zeros (MUL: iff both Result and MulHi are zero).
REQ-027 Result, MulHi and flags SHALL hold their value from Done until the next completed operation; during MUL they SHALL keep the previous values.
REQ-028 Unused Op codes SHALL not exist; all eight codes are defined above.

Reset
REQ-029 Reset low at a clock edge SHALL force IDLE and clear Busy, Done, Result, MulHi, Zero, Overflow, CarryOut to 0, except Zero which SHALL reset to 1.
REQ-030 Reset during MUL SHALL abort the multiply; no Done SHALL follow.
REQ-031 Start sampled in the same cycle as active reset SHALL be discarded.

Verification (WIDTH=24)
REQ-032 ADD A=0x7FFFFF, B=0x000001 -> Done 1 cycle later, Result=0x800000, Overflow=1, CarryOut=0, Zero=0.
REQ-033 SUB A=5, B=5 -> Result=0, Zero=1, CarryOut=1, Overflow=0; SLT A=0xFFFFFF, B=1 -> Result=1.
REQ-034 MUL A=0xFFFFFF, B=0xFFFFFF -> Busy for 24 cycles, Done at cycle 25, MulHi=0xFFFFFE, Result=0x000001; Start pulses during Busy ignored.
REQ-035 SLL A=1, SHAMT=4, B=3 -> Result=0x000080; SLL A=1, SHAMT=20, B=4 -> Result=0, Zero=1; SRL A=0x800000, SHAMT=23, B=0 -> Result=1.
REQ-036 MUL started, Reset low at cycle 10 -> all outputs 0 (Zero=1) next edge, no Done; new ADD 2+3 after release -> Result=5.
REQ-037 Back-to-back: Start held high with AND ops -> one op accepted every 2 cycles, Done every 2 cycles.

Source files
------------

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Small ALU with single-cycle logic/arith/shift ops and a multi-cycle
//   unsigned shift-add multiplier. Results and flags are registered and
//   announced by a one-cycle done pulse.
//
// Ports
//   clk_i        single clock, rising edge
//   rstN_i       synchronous active-low reset
//   start_i      operation request, sampled with op_i/a_i/b_i/shamt_i
//   op_i         000 AND, 001 OR, 010 ADD, 011 SLL, 100 MUL, 101 SRL,
//                110 SUB, 111 SLT
//   a_i, b_i     operands
//   shamt_i      base shift amount (added to b_i[SHW-1:0])
//   busy_o       high while a multiply is running
//   done_o       one-cycle pulse, result/flags valid
//   result_o     result (low product half for MUL)
//   mulHi_o      high product half for MUL, 0 otherwise
//   zero_o       result (and mulHi for MUL) all zero
//   overflow_o   signed overflow of ADD/SUB
//   carryOut_o   adder carry out of ADD/SUB (SUB: 1 = no borrow)
// ---------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rstN_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] mulHi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             carryOut_o
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSll = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;
  localparam logic [2:0] OpSrl = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam int CW = $clog2(WIDTH);
  localparam logic [SHW:0]  WidthS  = (SHW+1)'(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_e;

  state_e           state_q;
  logic             busy_q, done_q, zero_q, overflow_q, carryOut_q;
  logic [WIDTH-1:0] result_q, mulHi_q;
  logic [WIDTH-1:0] mcand_q, prodHi_q, prodLo_q;
  logic [CW-1:0]    cnt_q;

  // Shared adder: SUB and SLT both compute A + ~B + 1
  logic             isSub;
  logic [WIDTH-1:0] bOp, addSum;
  logic             addCarry, addOvf;
  logic [SHW:0]     shDist;

  assign isSub = (op_i == OpSub) || (op_i == OpSlt);
  assign bOp   = isSub ? ~b_i : b_i;
  assign {addCarry, addSum} = {1'b0, a_i} + {1'b0, bOp} + {{WIDTH{1'b0}}, isSub};
  // Carry into the MSB is recovered from the MSB sum bit
  assign addOvf = (a_i[WIDTH-1] ^ bOp[WIDTH-1] ^ addSum[WIDTH-1]) ^ addCarry;
  // One extra bit so the sum of two shift fields cannot wrap
  assign shDist = {1'b0, shamt_i} + {1'b0, b_i[SHW-1:0]};

  // Single-cycle result and flags, loaded on the accepting edge
  logic [WIDTH-1:0] aluResult_d;
  logic             aluCarry_d, aluOvf_d;

  always_comb begin
    aluResult_d = '0;
    aluCarry_d  = 1'b0;
    aluOvf_d    = 1'b0;
    case (op_i)
      OpAnd: aluResult_d = a_i & b_i;
      OpOr:  aluResult_d = a_i | b_i;
      OpAdd, OpSub: begin
        aluResult_d = addSum;
        aluCarry_d  = addCarry;
        aluOvf_d    = addOvf;
      end
      // Sign of the difference, corrected when the subtraction overflowed
      OpSlt: aluResult_d = {{(WIDTH-1){1'b0}}, addSum[WIDTH-1] ^ addOvf};
      OpSll: aluResult_d = (shDist >= WidthS) ? '0 : (a_i << shDist);
      OpSrl: aluResult_d = (shDist >= WidthS) ? '0 : (a_i >> shDist);
      default: aluResult_d = '0;
    endcase
  end

  // One shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi_d, mulLo_d;

  assign mulSum  = {1'b0, prodHi_q} + (prodLo_q[0] ? {1'b0, mcand_q} : '0);
  assign mulHi_d = mulSum[WIDTH:1];
  assign mulLo_d = {mulSum[0], prodLo_q[WIDTH-1:1]};

  // Control FSM with registered outputs; output registers change only when
  // an operation completes, so they hold across a running multiply.
  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mulHi_q    <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      carryOut_q <= 1'b0;
      mcand_q    <= '0;
      prodHi_q   <= '0;
      prodLo_q   <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (op_i == OpMul) begin
              mcand_q  <= a_i;
              prodLo_q <= b_i;
              prodHi_q <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= MUL;
            end else begin
              result_q   <= aluResult_d;
              mulHi_q    <= '0;
              zero_q     <= (aluResult_d == '0);
              overflow_q <= aluOvf_d;
              carryOut_q <= aluCarry_d;
              done_q     <= 1'b1;
              state_q    <= FIN;
            end
          end
        end
        MUL: begin
          prodHi_q <= mulHi_d;
          prodLo_q <= mulLo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            result_q   <= mulLo_d;
            mulHi_q    <= mulHi_d;
            zero_q     <= (mulLo_d == '0) && (mulHi_d == '0);
            overflow_q <= 1'b0;
            carryOut_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign mulHi_o    = mulHi_q;
  assign zero_o     = zero_q;
  assign overflow_o = overflow_q;
  assign carryOut_o = carryOut_q;

endmodule
